// File: rtl/prm_edge_scan_ctrl.sv
// Edge-obstacle sweep sequencer: issues consecutive edge codes to the checker bank, packs the
// returned mask bits LSB-first into words and streams them out with valid/ready.
module prm_edge_scan_ctrl #(
  parameter int unsigned CODE_W  = 15,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CHK_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] base_code,
  input  logic [CNT_W-1:0]  num_codes,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] chk_code,
  output logic              chk_vld,
  input  logic              chk_mask,
  output logic [WORD_W-1:0] out_word,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last,
  output logic [CNT_W-1:0]  blocked_cnt
);

  localparam int unsigned PCNT_W = $clog2(WORD_W + 1);
  localparam int unsigned TOT_W  = $clog2(2 * WORD_W + CHK_LAT + 1);
  localparam logic [PCNT_W-1:0] PackFull = PCNT_W'(WORD_W);
  localparam logic [TOT_W-1:0]  OneWord  = TOT_W'(WORD_W);
  localparam logic [TOT_W-1:0]  TwoWords = TOT_W'(2 * WORD_W);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFlush, StFin} state_e;

  state_e state_q, state_d;

  logic [CODE_W-1:0] next_code_q, next_code_d;
  logic [CODE_W-1:0] chk_code_q, chk_code_d;
  logic              chk_vld_q, chk_vld_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]  blocked_q, blocked_d;
  logic [CHK_LAT-1:0] lat_q, lat_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [PCNT_W-1:0] pack_cnt_q, pack_cnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;

  logic [TOT_W-1:0]  inflight, total;
  logic [CNT_W-1:0]  idx_inc;
  logic              room_ok, issue, sample, hold_free, move;

  // Bits not yet in the holding register: packed plus still in the checker pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CHK_LAT; i++) begin
      inflight = inflight + TOT_W'(lat_q[i]);
    end
    total = TOT_W'(pack_cnt_q) + inflight;
  end

  // An empty holding register can absorb one full packer, so a second word of room exists.
  assign room_ok   = (total < OneWord) || (!out_vld_q && (total < TwoWords));
  assign issue     = (state_q == StIssue) && room_ok;
  assign idx_inc   = idx_q + CNT_W'(1);
  assign sample    = lat_q[CHK_LAT-1];
  assign hold_free = !out_vld_q || out_rdy;
  assign move      = hold_free &&
                     ((pack_cnt_q == PackFull) || ((state_q == StFlush) && (pack_cnt_q != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_codes == '0) ? StFin : StIssue;
      StIssue: if (issue && (idx_inc == num_q)) state_d = StDrain;
      StDrain: if (lat_q == '0) state_d = StFlush;
      StFlush: if (out_vld_q && out_rdy && out_last_q) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFin);
  end

  always_comb begin
    next_code_d = next_code_q;
    chk_code_d  = chk_code_q;
    chk_vld_d   = issue;
    num_d       = num_q;
    idx_d       = idx_q;
    res_cnt_d   = res_cnt_q;
    blocked_d   = blocked_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    hold_d      = hold_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;

    lat_d[0] = issue;
    for (int i = 1; i < CHK_LAT; i++) begin
      lat_d[i] = lat_q[i-1];
    end

    if (issue) begin
      chk_code_d  = next_code_q;
      next_code_d = next_code_q + CODE_W'(1);
      idx_d       = idx_inc;
    end

    if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    // A word is final once every requested result has already landed in the packer.
    if (move) begin
      hold_d     = pack_q;
      out_vld_d  = 1'b1;
      out_last_d = (res_cnt_q == num_q);
      pack_d     = '0;
      pack_cnt_d = '0;
    end

    if (sample) begin
      pack_d     = pack_d | (WORD_W'(chk_mask) << pack_cnt_d);
      pack_cnt_d = pack_cnt_d + PCNT_W'(1);
      res_cnt_d  = res_cnt_q + CNT_W'(1);
      if (chk_mask && (blocked_q != '1)) blocked_d = blocked_q + CNT_W'(1);
    end

    if ((state_q == StIdle) && start && !abort) begin
      next_code_d = base_code;
      num_d       = num_codes;
      idx_d       = '0;
      res_cnt_d   = '0;
      blocked_d   = '0;
    end

    if (abort) begin
      chk_vld_d  = 1'b0;
      lat_d      = '0;
      pack_d     = '0;
      pack_cnt_d = '0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_code_q <= '0;
      chk_code_q  <= '0;
      chk_vld_q   <= 1'b0;
      num_q       <= '0;
      idx_q       <= '0;
      res_cnt_q   <= '0;
      blocked_q   <= '0;
      lat_q       <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      hold_q      <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      next_code_q <= next_code_d;
      chk_code_q  <= chk_code_d;
      chk_vld_q   <= chk_vld_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      res_cnt_q   <= res_cnt_d;
      blocked_q   <= blocked_d;
      lat_q       <= lat_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      hold_q      <= hold_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
    end
  end

  assign chk_code    = chk_code_q;
  assign chk_vld     = chk_vld_q;
  assign out_word    = hold_q;
  assign out_vld     = out_vld_q;
  assign out_last    = out_last_q;
  assign blocked_cnt = blocked_q;

endmodule
